// File: rtl/tl45_pkg.sv
// Shared TL45 definitions: memory opcodes, memory-stage FSM states and the
// writeback pair carried between pipeline stages.
package tl45_pkg;

  localparam logic [4:0] OP_LW = 5'h14;
  localparam logic [4:0] OP_SW = 5'h15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT_ACK,
    S_HOLD
  } mem_state_e;

  typedef struct packed {
    logic [3:0]  dr;
    logic [31:0] value;
  } wb_result_t;

endpackage

// File: rtl/tl45_memory.sv
// TL45 memory-access stage: passes ALU results through, or runs one single-beat
// pipelined Wishbone transfer for LW/SW while stalling the ALU stage.
module tl45_memory #(
  parameter logic [4:0] OP_LW = tl45_pkg::OP_LW,
  parameter logic [4:0] OP_SW = tl45_pkg::OP_SW
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  output logic        o_pipe_stall,
  input  logic        i_pipe_flush,
  output logic        o_pipe_flush,
  input  logic [4:0]  i_opcode,
  input  logic [3:0]  i_dr,
  input  logic [31:0] i_value,
  input  logic [31:0] i_store_val,
  output logic [3:0]  o_dr,
  output logic [31:0] o_value,
  output logic [3:0]  o_of_reg,
  output logic [31:0] o_of_val,
  output logic        o_mem_fault,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [29:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_stall,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_data
);
  import tl45_pkg::*;

  mem_state_e  state_q, state_d;
  wb_result_t  out_q, out_d;
  wb_result_t  hold_q, hold_d;
  logic        fault_q, fault_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;

  logic       is_mem, misaligned, complete, local_stall;
  wb_result_t result;

  assign is_mem     = (i_opcode == OP_LW) || (i_opcode == OP_SW);
  assign misaligned = (i_value[1:0] != 2'b00);

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    hold_d      = hold_q;
    fault_d     = 1'b0;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    complete    = 1'b0;
    local_stall = 1'b0;
    result      = '0;
    o_of_reg    = 4'd0;
    o_of_val    = 32'd0;

    if (!is_mem) begin
      o_of_reg = i_dr;
      o_of_val = i_value;
    end

    case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          // A misaligned access is consumed at once, so the ALU must advance.
          local_stall = !misaligned;
          if (!i_pipe_stall) begin
            if (misaligned) begin
              out_d   = '0;
              fault_d = 1'b1;
            end else begin
              cyc_d   = 1'b1;
              stb_d   = 1'b1;
              we_d    = (i_opcode == OP_SW);
              addr_d  = i_value[31:2];
              data_d  = i_store_val;
              state_d = S_STROBE;
            end
          end
        end else if (!i_pipe_stall) begin
          out_d = '{dr: i_dr, value: i_value};
        end
      end
      S_STROBE: begin
        local_stall = 1'b1;
        if (!i_wb_stall) begin
          stb_d    = 1'b0;
          state_d  = S_WAIT_ACK;
          complete = i_wb_ack || i_wb_err;
        end
      end
      S_WAIT_ACK: begin
        local_stall = 1'b1;
        complete    = i_wb_ack || i_wb_err;
      end
      S_HOLD: begin
        local_stall = 1'b1;
        if (!i_pipe_stall) begin
          local_stall = 1'b0;
          out_d       = hold_q;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      cyc_d = 1'b0;
      if (i_wb_err) begin
        fault_d = 1'b1;
      end else if (!we_q) begin
        result   = '{dr: i_dr, value: i_wb_data};
        o_of_reg = i_dr;
        o_of_val = i_wb_data;
      end
      if (!i_pipe_stall) begin
        local_stall = 1'b0;
        out_d       = result;
        state_d     = S_IDLE;
      end else begin
        hold_d  = result;
        state_d = S_HOLD;
      end
    end

    // Flush aborts everything; a late ack then lands in IDLE and is ignored.
    if (i_pipe_flush) begin
      out_d   = '0;
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      state_d = S_IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      hold_q  <= '0;
      fault_q <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      hold_q  <= hold_d;
      fault_q <= fault_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign o_pipe_stall = i_pipe_stall || local_stall;
  assign o_pipe_flush = i_pipe_flush;
  assign o_dr         = out_q.dr;
  assign o_value      = out_q.value;
  assign o_mem_fault  = fault_q;
  assign o_wb_cyc     = cyc_q;
  assign o_wb_stb     = stb_q;
  assign o_wb_we      = we_q;
  assign o_wb_addr    = addr_q;
  assign o_wb_data    = data_q;
  assign o_wb_sel     = 4'hF;

endmodule

// File: tb/tb_tl45_memory.sv
// Directed bench for tl45_memory: expected writeback pairs are queued when an
// instruction is driven and compared when its result reaches o_dr/o_value.
module tb_tl45_memory;

  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_LW  = 5'h14;
  localparam logic [4:0] OP_SW  = 5'h15;

  typedef struct packed {
    logic [3:0]  dr;
    logic [31:0] val;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        pipe_stall_i, pipe_stall_o;
  logic        pipe_flush_i, pipe_flush_o;
  logic [4:0]  opcode;
  logic [3:0]  dr;
  logic [31:0] value, store_val;
  logic [3:0]  o_dr, of_reg;
  logic [31:0] o_value, of_val;
  logic        mem_fault;
  logic        wb_cyc, wb_stb, wb_we;
  logic [29:0] wb_addr;
  logic [31:0] wb_wdata, wb_rdata;
  logic [3:0]  wb_sel;
  logic        wb_stall, wb_ack, wb_err;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  tl45_memory dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_pipe_stall (pipe_stall_i),
    .o_pipe_stall (pipe_stall_o),
    .i_pipe_flush (pipe_flush_i),
    .o_pipe_flush (pipe_flush_o),
    .i_opcode     (opcode),
    .i_dr         (dr),
    .i_value      (value),
    .i_store_val  (store_val),
    .o_dr         (o_dr),
    .o_value      (o_value),
    .o_of_reg     (of_reg),
    .o_of_val     (of_val),
    .o_mem_fault  (mem_fault),
    .o_wb_cyc     (wb_cyc),
    .o_wb_stb     (wb_stb),
    .o_wb_we      (wb_we),
    .o_wb_addr    (wb_addr),
    .o_wb_data    (wb_wdata),
    .o_wb_sel     (wb_sel),
    .i_wb_stall   (wb_stall),
    .i_wb_ack     (wb_ack),
    .i_wb_err     (wb_err),
    .i_wb_data    (wb_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: observed result with empty scoreboard expected a queued entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".dr"}, {28'd0, o_dr}, {28'd0, e.dr});
      check({tag, ".value"}, o_value, e.val);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [3:0] d, input logic [31:0] v,
                       input logic [31:0] sv);
    opcode    = op;
    dr        = d;
    value     = v;
    store_val = sv;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    pipe_stall_i = 1'b0;
    pipe_flush_i = 1'b0;
    drive(OP_NOP, 4'd0, 32'd0, 32'd0);
    wb_stall = 1'b0;
    wb_ack   = 1'b0;
    wb_err   = 1'b0;
    wb_rdata = 32'd0;

    // Reset state
    step();
    step();
    check("rst.dr", {28'd0, o_dr}, 32'd0);
    check("rst.value", o_value, 32'd0);
    check("rst.fault", {31'd0, mem_fault}, 32'd0);
    check("rst.cyc", {31'd0, wb_cyc}, 32'd0);
    check("rst.stb", {31'd0, wb_stb}, 32'd0);
    check("rst.addr", {2'd0, wb_addr}, 32'd0);
    reset = 1'b0;

    // ADD pass-through
    step();
    drive(OP_ADD, 4'd3, 32'h1234, 32'd0);
    sb.push_back('{dr: 4'd3, val: 32'h1234});
    #1;
    check("add.of_reg", {28'd0, of_reg}, 32'd3);
    check("add.of_val", of_val, 32'h1234);
    check("add.stall", {31'd0, pipe_stall_o}, 32'd0);
    step();
    sb_check("add");

    // LW with a zero-wait slave
    drive(OP_LW, 4'd5, 32'h100, 32'd0);
    sb.push_back('{dr: 4'd5, val: 32'hDEADBEEF});
    #1;
    check("lw.c0.stall", {31'd0, pipe_stall_o}, 32'd1);
    check("lw.c0.of_reg", {28'd0, of_reg}, 32'd0);
    step();
    check("lw.c1.cyc", {31'd0, wb_cyc}, 32'd1);
    check("lw.c1.stb", {31'd0, wb_stb}, 32'd1);
    check("lw.c1.we", {31'd0, wb_we}, 32'd0);
    check("lw.c1.addr", {2'd0, wb_addr}, 32'h40);
    check("lw.c1.sel", {28'd0, wb_sel}, 32'hF);
    check("lw.c1.stall", {31'd0, pipe_stall_o}, 32'd1);
    step();
    check("lw.c2.stb", {31'd0, wb_stb}, 32'd0);
    wb_ack = 1'b1;
    wb_rdata = 32'hDEADBEEF;
    #1;
    check("lw.c2.stall", {31'd0, pipe_stall_o}, 32'd0);
    check("lw.c2.of_reg", {28'd0, of_reg}, 32'd5);
    check("lw.c2.of_val", of_val, 32'hDEADBEEF);
    step();
    wb_ack = 1'b0;
    sb_check("lw");
    check("lw.c3.cyc", {31'd0, wb_cyc}, 32'd0);

    // SW with two slave stall cycles, preceded by an ADD so o_dr is nonzero
    drive(OP_ADD, 4'd9, 32'h55, 32'd0);
    sb.push_back('{dr: 4'd9, val: 32'h55});
    step();
    sb_check("add2");
    drive(OP_SW, 4'd7, 32'h8, 32'hA5A5A5A5);
    wb_stall = 1'b1;
    sb.push_back('{dr: 4'd0, val: 32'd0});
    step();
    check("sw.c1.stb", {31'd0, wb_stb}, 32'd1);
    check("sw.c1.we", {31'd0, wb_we}, 32'd1);
    check("sw.c1.data", wb_wdata, 32'hA5A5A5A5);
    check("sw.c1.addr", {2'd0, wb_addr}, 32'h2);
    step();
    check("sw.c2.stb", {31'd0, wb_stb}, 32'd1);
    check("sw.c2.dr_held", {28'd0, o_dr}, 32'd9);
    step();
    check("sw.c3.stb", {31'd0, wb_stb}, 32'd1);
    wb_stall = 1'b0;
    step();
    check("sw.c4.stb", {31'd0, wb_stb}, 32'd0);
    check("sw.c4.cyc", {31'd0, wb_cyc}, 32'd1);
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    sb_check("sw");
    drive(OP_NOP, 4'd0, 32'd0, 32'd0);

    // Misaligned LW
    step();
    drive(OP_ADD, 4'd2, 32'h77, 32'd0);
    sb.push_back('{dr: 4'd2, val: 32'h77});
    step();
    sb_check("add3");
    drive(OP_LW, 4'd4, 32'h102, 32'd0);
    sb.push_back('{dr: 4'd0, val: 32'd0});
    step();
    check("mis.cyc", {31'd0, wb_cyc}, 32'd0);
    check("mis.fault", {31'd0, mem_fault}, 32'd1);
    sb_check("mis");
    drive(OP_NOP, 4'd0, 32'd0, 32'd0);
    step();
    check("mis.fault_pulse", {31'd0, mem_fault}, 32'd0);

    // LW answered with a bus error
    drive(OP_ADD, 4'd6, 32'h66, 32'd0);
    sb.push_back('{dr: 4'd6, val: 32'h66});
    step();
    sb_check("add4");
    drive(OP_LW, 4'd6, 32'h200, 32'd0);
    sb.push_back('{dr: 4'd0, val: 32'd0});
    step();
    check("err.c1.stb", {31'd0, wb_stb}, 32'd1);
    step();
    wb_err = 1'b1;
    wb_rdata = 32'h12345678;
    #1;
    check("err.c2.of_reg", {28'd0, of_reg}, 32'd0);
    step();
    wb_err = 1'b0;
    check("err.fault", {31'd0, mem_fault}, 32'd1);
    check("err.cyc", {31'd0, wb_cyc}, 32'd0);
    sb_check("err");
    drive(OP_NOP, 4'd0, 32'd0, 32'd0);
    step();
    check("err.fault_pulse", {31'd0, mem_fault}, 32'd0);

    // Flush while waiting for ack, then a late ack
    drive(OP_ADD, 4'd1, 32'h11, 32'd0);
    sb.push_back('{dr: 4'd1, val: 32'h11});
    step();
    sb_check("add5");
    drive(OP_LW, 4'd8, 32'h300, 32'd0);
    step();
    step();
    check("fl.c2.cyc", {31'd0, wb_cyc}, 32'd1);
    pipe_flush_i = 1'b1;
    sb.push_back('{dr: 4'd0, val: 32'd0});
    #1;
    check("fl.flush_out", {31'd0, pipe_flush_o}, 32'd1);
    step();
    pipe_flush_i = 1'b0;
    check("fl.c3.cyc", {31'd0, wb_cyc}, 32'd0);
    sb_check("flush");
    drive(OP_NOP, 4'd0, 32'd0, 32'd0);
    wb_ack = 1'b1;
    wb_rdata = 32'hBAD0BAD0;
    step();
    wb_ack = 1'b0;
    check("fl.late.cyc", {31'd0, wb_cyc}, 32'd0);
    check("fl.late.value", o_value, 32'd0);

    // Downstream stall while the ack arrives: result parked in HOLD
    drive(OP_ADD, 4'hD, 32'h0DD0, 32'd0);
    sb.push_back('{dr: 4'hD, val: 32'h0DD0});
    step();
    sb_check("add6");
    drive(OP_LW, 4'hB, 32'h400, 32'd0);
    sb.push_back('{dr: 4'hB, val: 32'hCAFEF00D});
    step();
    step();
    wb_ack = 1'b1;
    wb_rdata = 32'hCAFEF00D;
    pipe_stall_i = 1'b1;
    #1;
    check("hold.c2.stall", {31'd0, pipe_stall_o}, 32'd1);
    step();
    wb_ack = 1'b0;
    wb_rdata = 32'd0;
    check("hold.c3.dr", {28'd0, o_dr}, 32'hD);
    check("hold.c3.cyc", {31'd0, wb_cyc}, 32'd0);
    step();
    check("hold.c4.value", o_value, 32'h0DD0);
    pipe_stall_i = 1'b0;
    step();
    sb_check("hold");

    // Reset asserted mid-transfer
    drive(OP_LW, 4'hC, 32'h500, 32'h11112222);
    step();
    check("rst2.c1.cyc", {31'd0, wb_cyc}, 32'd1);
    check("rst2.c1.dr", {28'd0, o_dr}, 32'hB);
    #1;
    reset = 1'b1;
    #1;
    check("rst2.cyc", {31'd0, wb_cyc}, 32'd0);
    check("rst2.stb", {31'd0, wb_stb}, 32'd0);
    check("rst2.dr", {28'd0, o_dr}, 32'd0);
    check("rst2.value", o_value, 32'd0);
    check("rst2.addr", {2'd0, wb_addr}, 32'd0);
    step();
    reset = 1'b0;
    drive(OP_NOP, 4'd0, 32'd0, 32'd0);
    #1;
    check("rst2.stall", {31'd0, pipe_stall_o}, 32'd0);
    step();
    drive(OP_ADD, 4'hE, 32'h0E0E, 32'd0);
    sb.push_back('{dr: 4'hE, val: 32'h0E0E});
    step();
    sb_check("add7");
    check("sb.empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
